// File: rtl/mpt_mem_read_arbiter.sv
// rtl/mpt_mem_read_arbiter.sv - round-robin read arbiter sharing one memory master port
//
// Purpose: arbitrates NUM_REQ read requesters onto a single req/gnt/valid memory
// port. Every grant pushes the winner ID into an in-order ID FIFO. Each response
// is routed to the requester whose ID sits at the FIFO head.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   req_mem_req_i/addr_i      per-requester request and address (slice i = requester i)
//   req_mem_gnt_o             per-requester grant (same cycle as memory grant)
//   req_mem_valid_o/rdata_o   per-requester response valid, shared response data
//   memory_master_mem_*       memory master port (read only: we/be/wdata tied 0)
//   outstanding_o             ID FIFO occupancy
//   error_o                   sticky flag: response arrived with no outstanding ID
module mpt_mem_read_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int MAX_OUTSTANDING   = 4,
  parameter int MEMORY_DATA_WIDTH = 32,
  parameter int MEMORY_ADDR_WIDTH = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_REQ-1:0]                   req_mem_req_i,
  input  logic [NUM_REQ*MEMORY_ADDR_WIDTH-1:0] req_mem_addr_i,
  output logic [NUM_REQ-1:0]                   req_mem_gnt_o,
  output logic [NUM_REQ-1:0]                   req_mem_valid_o,
  output logic [MEMORY_DATA_WIDTH-1:0]         req_mem_rdata_o,
  output logic                                 memory_master_mem_req,
  output logic [MEMORY_ADDR_WIDTH-1:0]         memory_master_mem_addr,
  output logic                                 memory_master_mem_we,
  output logic [MEMORY_DATA_WIDTH/8-1:0]       memory_master_mem_be,
  output logic [MEMORY_DATA_WIDTH-1:0]         memory_master_mem_wdata,
  input  logic                                 memory_master_mem_gnt,
  input  logic                                 memory_master_mem_valid,
  input  logic [MEMORY_DATA_WIDTH-1:0]         memory_master_mem_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
  output logic                                 error_o
);

  localparam int             IDW      = $clog2(NUM_REQ);
  localparam int             AW       = $clog2(MAX_OUTSTANDING);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(MAX_OUTSTANDING);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] locked_id_q, locked_id_d;
  logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [IDW-1:0] fifo_d [MAX_OUTSTANDING];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           error_q, error_d;

  logic [IDW-1:0] hi_sel, lo_sel, rr_sel, sel, head;
  logic           found_hi, found_lo;
  logic           any_req, fifo_full, fifo_empty, push, pop;

  // Round-robin pick: the first request at or above the pointer wins; if none,
  // the first request below it wins (the wrapped part of the scan).
  always_comb begin
    hi_sel   = '0;
    lo_sel   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_mem_req_i[i]) begin
        if (i >= int'(ptr_q)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            hi_sel   = IDW'(i);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          lo_sel   = IDW'(i);
        end
      end
    end
    rr_sel = found_hi ? hi_sel : lo_sel;
  end

  // A request that saw no grant stays pinned so the address cannot change under it.
  assign sel        = lock_q ? locked_id_q : rr_sel;
  assign any_req    = |req_mem_req_i;
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Full stalls the request even if a pop frees a slot this cycle.
  assign memory_master_mem_req = any_req && !fifo_full;
  assign push = memory_master_mem_req && memory_master_mem_gnt;
  assign pop  = memory_master_mem_valid && !fifo_empty;

  always_comb begin
    req_mem_gnt_o          = '0;
    req_mem_valid_o        = '0;
    memory_master_mem_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push && (sel == IDW'(i))) req_mem_gnt_o[i] = 1'b1;
      if (pop && (head == IDW'(i))) req_mem_valid_o[i] = 1'b1;
      if (any_req && (sel == IDW'(i)))
        memory_master_mem_addr = req_mem_addr_i[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
    end
  end

  assign req_mem_rdata_o         = memory_master_mem_rdata;
  assign memory_master_mem_we    = 1'b0;
  assign memory_master_mem_be    = '0;
  assign memory_master_mem_wdata = '0;
  assign outstanding_o           = count_q;
  assign error_o                 = error_q;

  // ID FIFO next state
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, lock and error next state
  always_comb begin
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    error_d     = error_q | (memory_master_mem_valid & fifo_empty);
    if (push) begin
      ptr_d  = (sel == LAST_ID) ? '0 : sel + IDW'(1);
      lock_d = 1'b0;
    end else if (memory_master_mem_req) begin
      lock_d      = 1'b1;
      locked_id_d = sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      locked_id_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      error_q     <= error_d;
      fifo_q      <= fifo_d;
    end
  end

endmodule

// File: tb/tb_mpt_mem_read_arbiter.sv
// tb/tb_mpt_mem_read_arbiter.sv - self-checking bench for mpt_mem_read_arbiter
module tb_mpt_mem_read_arbiter;
  localparam int N  = 4;
  localparam int MO = 4;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_1000;
  localparam logic [31:0] A2 = 32'h0000_2000;
  localparam logic [31:0] A3 = 32'h0000_3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [31:0]   addr [N];
  logic [N*32-1:0] addr_flat;
  logic [N-1:0]  gnt_o, valid_o;
  logic [31:0]   rdata_o;
  logic          m_req, m_we, m_gnt, m_valid;
  logic [31:0]   m_addr, m_wdata, m_rdata;
  logic [3:0]    m_be;
  logic [2:0]    outst;
  logic          err;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    addr_flat = '0;
    for (int i = 0; i < N; i++) addr_flat[i*32 +: 32] = addr[i];
  end

  mpt_mem_read_arbiter #(
    .NUM_REQ(N), .MAX_OUTSTANDING(MO), .MEMORY_DATA_WIDTH(32), .MEMORY_ADDR_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_mem_req_i(req), .req_mem_addr_i(addr_flat),
    .req_mem_gnt_o(gnt_o), .req_mem_valid_o(valid_o), .req_mem_rdata_o(rdata_o),
    .memory_master_mem_req(m_req), .memory_master_mem_addr(m_addr),
    .memory_master_mem_we(m_we), .memory_master_mem_be(m_be),
    .memory_master_mem_wdata(m_wdata), .memory_master_mem_gnt(m_gnt),
    .memory_master_mem_valid(m_valid), .memory_master_mem_rdata(m_rdata),
    .outstanding_o(outst), .error_o(err)
  );

  typedef struct {
    bit          rst;
    logic [3:0]  r;
    logic        g;
    logic        v;
    logic [31:0] rd;
    logic [3:0]  eg;
    logic [3:0]  ev;
    logic        em;
    logic [31:0] ea;
    logic [2:0]  eo;
    logic        ee;
  } vec_t;
  vec_t tbl [$];

  task automatic add(input bit rst, input logic [3:0] r, input logic g, input logic v,
                     input logic [31:0] rd, input logic [3:0] eg, input logic [3:0] ev,
                     input logic em, input logic [31:0] ea, input logic [2:0] eo, input logic ee);
    vec_t x;
    x.rst = rst; x.r = r; x.g = g; x.v = v; x.rd = rd;
    x.eg = eg; x.ev = ev; x.em = em; x.ea = ea; x.eo = eo; x.ee = ee;
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    req = '0; m_gnt = 1'b0; m_valid = 1'b0; m_rdata = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: drive at posedge+1, check combinational and registered outputs at
  // the falling edge, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] r, input logic g, input logic v,
                     input logic [31:0] rd, input logic [3:0] eg, input logic [3:0] ev,
                     input logic em, input logic [31:0] ea, input logic [2:0] eo, input logic ee);
    req = r; m_gnt = g; m_valid = v; m_rdata = rd;
    @(negedge clk);
    chk({tag, ".gnt"},   32'(gnt_o),   32'(eg));
    chk({tag, ".valid"}, 32'(valid_o), 32'(ev));
    chk({tag, ".mreq"},  32'(m_req),   32'(em));
    chk({tag, ".addr"},  m_addr,       ea);
    chk({tag, ".outst"}, 32'(outst),   32'(eo));
    chk({tag, ".err"},   32'(err),     32'(ee));
    if (ev != 4'b0) chk({tag, ".rdata"}, rdata_o, rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    int q [$];
    int rr, lid;
    bit lk, merr;

    addr[0] = A0; addr[1] = A1; addr[2] = A2; addr[3] = A3;
    req = '0; m_gnt = 1'b0; m_valid = 1'b0; m_rdata = '0;
    rst_n = 1'b0;
    #3;
    chk("reset.outst", 32'(outst), 32'd0);
    chk("reset.err",   32'(err),   32'd0);
    chk("reset.mreq",  32'(m_req), 32'd0);
    chk("reset.gnt",   32'(gnt_o), 32'd0);
    chk("reset.valid", 32'(valid_o), 32'd0);
    chk("tie.we",      32'(m_we),  32'd0);
    chk("tie.be",      32'(m_be),  32'd0);
    chk("tie.wdata",   m_wdata,    32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single requester
    add(1, 4'b0010, 1, 0, 32'h0,         4'b0010, 4'b0000, 1, A1, 0, 0);
    add(0, 4'b0000, 1, 0, 32'h0,         4'b0000, 4'b0000, 0, 0,  1, 0);
    add(0, 4'b0000, 1, 1, 32'hCAFE0001,  4'b0000, 4'b0010, 0, 0,  1, 0);
    add(0, 4'b0000, 1, 0, 32'h0,         4'b0000, 4'b0000, 0, 0,  0, 0);
    // round robin 0,1,2,3,0 with a response each cycle (push+pop keeps occupancy)
    add(1, 4'b1111, 1, 0, 32'h0,  4'b0001, 4'b0000, 1, A0, 0, 0);
    add(0, 4'b1111, 1, 1, 32'hB1, 4'b0010, 4'b0001, 1, A1, 1, 0);
    add(0, 4'b1111, 1, 1, 32'hB2, 4'b0100, 4'b0010, 1, A2, 1, 0);
    add(0, 4'b1111, 1, 1, 32'hB3, 4'b1000, 4'b0100, 1, A3, 1, 0);
    add(0, 4'b1111, 1, 1, 32'hB4, 4'b0001, 4'b1000, 1, A0, 1, 0);
    add(0, 4'b0000, 0, 1, 32'hB5, 4'b0000, 4'b0001, 0, 0,  1, 0);
    // fill the FIFO, stall while full (also during a pop), then drain
    add(0, 4'b1111, 1, 0, 32'h0,  4'b0010, 4'b0000, 1, A1, 0, 0);
    add(0, 4'b1111, 1, 0, 32'h0,  4'b0100, 4'b0000, 1, A2, 1, 0);
    add(0, 4'b1111, 1, 0, 32'h0,  4'b1000, 4'b0000, 1, A3, 2, 0);
    add(0, 4'b1111, 1, 0, 32'h0,  4'b0001, 4'b0000, 1, A0, 3, 0);
    add(0, 4'b1111, 1, 0, 32'h0,  4'b0000, 4'b0000, 0, A1, 4, 0);
    add(0, 4'b1111, 1, 1, 32'hF1, 4'b0000, 4'b0010, 0, A1, 4, 0);
    add(0, 4'b1111, 1, 0, 32'h0,  4'b0010, 4'b0000, 1, A1, 3, 0);
    add(0, 4'b0000, 0, 1, 32'hF2, 4'b0000, 4'b0100, 0, 0,  4, 0);
    add(0, 4'b0000, 0, 1, 32'hF3, 4'b0000, 4'b1000, 0, 0,  3, 0);
    add(0, 4'b0000, 0, 1, 32'hF4, 4'b0000, 4'b0001, 0, 0,  2, 0);
    add(0, 4'b0000, 0, 1, 32'hF5, 4'b0000, 4'b0010, 0, 0,  1, 0);
    add(0, 4'b0000, 0, 0, 32'h0,  4'b0000, 4'b0000, 0, 0,  0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      cyc($sformatf("vec%0d", i), tbl[i].r, tbl[i].g, tbl[i].v, tbl[i].rd,
          tbl[i].eg, tbl[i].ev, tbl[i].em, tbl[i].ea, tbl[i].eo, tbl[i].ee);
    end

    // grant stall with lock: requester 2 must win despite requester 0 joining
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc("lock_stall", 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 1, A2, 0, 0);
    cyc("lock_hold",  4'b0101, 0, 0, 0, 4'b0000, 4'b0000, 1, A2, 0, 0);
    cyc("lock_gnt",   4'b0101, 1, 0, 0, 4'b0100, 4'b0000, 1, A2, 0, 0);
    cyc("lock_next",  4'b0001, 1, 0, 0, 4'b0001, 4'b0000, 1, A0, 1, 0);
    cyc("lock_rsp0",  4'b0000, 0, 1, 32'hD1, 4'b0000, 4'b0100, 0, 0, 2, 0);
    cyc("lock_rsp1",  4'b0000, 0, 1, 32'hD2, 4'b0000, 4'b0001, 0, 0, 1, 0);

    // interleaved routing 3,1,3 with a simultaneous grant and response
    cyc("il_g3",  4'b1000, 1, 0, 0,     4'b1000, 4'b0000, 1, A3, 0, 0);
    cyc("il_g1",  4'b0010, 1, 0, 0,     4'b0010, 4'b0000, 1, A1, 1, 0);
    cyc("il_g3v", 4'b1000, 1, 1, 32'hA, 4'b1000, 4'b1000, 1, A3, 2, 0);
    cyc("il_vB",  4'b0000, 0, 1, 32'hB, 4'b0000, 4'b0010, 0, 0,  2, 0);
    cyc("il_vC",  4'b0000, 0, 1, 32'hC, 4'b0000, 4'b1000, 0, 0,  1, 0);

    // spurious response, sticky error, async reset with two outstanding
    cyc("sp_v",    4'b0000, 0, 1, 32'hEE, 4'b0000, 4'b0000, 0, 0, 0, 0);
    cyc("sp_st0",  4'b0000, 0, 0, 0,      4'b0000, 4'b0000, 0, 0, 0, 1);
    cyc("sp_st1",  4'b0000, 0, 0, 0,      4'b0000, 4'b0000, 0, 0, 0, 1);
    cyc("sp_g0",   4'b0001, 1, 0, 0,      4'b0001, 4'b0000, 1, A0, 0, 1);
    cyc("sp_g1",   4'b0010, 1, 0, 0,      4'b0010, 4'b0000, 1, A1, 1, 1);
    req = '0; m_gnt = 1'b0; m_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.outst", 32'(outst), 32'd0);
    chk("arst.err",   32'(err),   32'd0);
    chk("arst.mreq",  32'(m_req), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("late_v",   4'b0000, 0, 1, 32'h77, 4'b0000, 4'b0000, 0, 0, 0, 0);
    cyc("late_err", 4'b0000, 0, 0, 0,      4'b0000, 4'b0000, 0, 0, 0, 1);

    // randomized traffic against a queue-based reference model
    do_reset();
    rr = 0; lk = 0; lid = 0; merr = 0;
    for (int c = 0; c < 3000; c++) begin
      int sel, gp, vp;
      logic [3:0] r, eg, ev;
      logic [31:0] ea, rd;
      bit g, v, em;
      case ((c / 250) % 3)
        0:       begin gp = 80; vp = 25; end
        1:       begin gp = 25; vp = 80; end
        default: begin gp = 60; vp = 60; end
      endcase
      r = 4'($urandom_range(0, 15));
      if (lk) r = r | 4'(1 << lid);
      for (int i = 0; i < N; i++)
        if (!(lk && i == lid)) addr[i] = $urandom;
      g  = ($urandom_range(0, 99) < gp);
      v  = (q.size() > 0) && ($urandom_range(0, 99) < vp);
      rd = $urandom;
      sel = 0;
      if (lk) sel = lid;
      else begin
        for (int k = 0; k < N; k++) begin
          if (r[(rr + k) % N]) begin
            sel = (rr + k) % N;
            break;
          end
        end
      end
      em = (r != 4'b0) && (q.size() < MO);
      ea = (r != 4'b0) ? addr[sel] : 32'h0;
      eg = (em && g) ? 4'(1 << sel) : 4'b0;
      ev = v ? 4'(1 << q[0]) : 4'b0;
      cyc("rand", r, g, v, rd, eg, ev, em, ea, 3'(q.size()), merr);
      if (v) void'(q.pop_front());
      if (em && g) begin
        q.push_back(sel);
        rr = (sel + 1) % N;
        lk = 0;
      end else if (em) begin
        lk = 1;
        lid = sel;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpt_mem_read_arbiter.md
Name: mpt_mem_read_arbiter

Overview:
- Shares one read-only memory master port (req/gnt/valid SRAM-style protocol) between NUM_REQ requester ports. Typical requesters are MPT walker read stages and a prefetch/refill path.
- Arbitrates requests round-robin.
- Records the winner ID of every granted transaction in an in-order ID FIFO. Each memory response (valid/rdata) is routed back to the requester whose ID is at the FIFO head.
- Sits between the MPT memory read stages and the memory interconnect.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- MAX_OUTSTANDING, 4, ID FIFO depth: maximum granted-but-unanswered transactions (power of 2, ≥2).
- MEMORY_DATA_WIDTH, 32, rdata width.
- MEMORY_ADDR_WIDTH, 32, address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_mem_req_i  in  NUM_REQ  per-requester request.
- req_mem_addr_i  in  NUM_REQ*MEMORY_ADDR_WIDTH  per-requester address; requester i occupies slice i.
- req_mem_gnt_o  out  NUM_REQ  per-requester grant.
- req_mem_valid_o  out  NUM_REQ  per-requester response valid.
- req_mem_rdata_o  out  MEMORY_DATA_WIDTH  response data, shared by all requesters; qualified by req_mem_valid_o.
- memory_master_mem_req  out  1  request to memory.
- memory_master_mem_addr  out  MEMORY_ADDR_WIDTH  address to memory.
- memory_master_mem_we  out  1  tied 0.
- memory_master_mem_be  out  MEMORY_DATA_WIDTH/8  tied 0.
- memory_master_mem_wdata  out  MEMORY_DATA_WIDTH  tied 0.
- memory_master_mem_gnt  in  1  memory grant.
- memory_master_mem_valid  in  1  memory response valid.
- memory_master_mem_rdata  in  MEMORY_DATA_WIDTH  memory response data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current ID FIFO occupancy.
- error_o  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, rst_ni=0):
  - ID FIFO emptied; outstanding_o=0.
  - Round-robin pointer=0; lock=0; error_o=0.
  - All gnt/valid outputs 0; memory_master_mem_req=0.
- Arbitration (combinational):
  - Scan req_mem_req_i starting at pointer and wrapping; the first asserted index is sel.
  - memory_master_mem_req = any request && !fifo_full.
  - memory_master_mem_addr = addr slice[sel]; drive '0 when there is no request.
- Lock:
  - If memory_master_mem_req=1 and memory_master_mem_gnt=0, set lock and register sel as locked_id.
  - While lock=1, sel=locked_id regardless of other requests, so the address stays stable until grant.
  - Lock clears on grant.
- Grant:
  - req_mem_gnt_o[sel] = memory_master_mem_req && memory_master_mem_gnt, in the same cycle. All other grant bits are 0.
  - On grant: push sel into the ID FIFO and set pointer = (sel+1) mod NUM_REQ at the next edge.
- Full:
  - When fifo_full, memory_master_mem_req=0 even if a pop occurs in the same cycle. This is deliberately conservative.
  - Lock is held through the full stall.
- Response:
  - Memory answers strictly in order, at least 1 cycle after grant.
  - On memory_master_mem_valid with FIFO not empty: req_mem_valid_o[head]=1 in the same cycle; req_mem_rdata_o = memory_master_mem_rdata; pop the head.
  - Responses are routed combinationally with 0 added latency. Requesters are always ready to accept responses.
- Simultaneous push and pop: occupancy is unchanged, and FIFO ordering is preserved.
- Error:
  - memory_master_mem_valid while FIFO empty sets error_o, which stays set until reset.
  - The response is dropped; no req_mem_valid_o is asserted.
- Reset mid-operation: all outstanding IDs are lost. Any late responses arriving afterwards hit an empty FIFO and set error_o.
- A requester may drop its req before grant only when it is not locked. Dropping req while locked is a requester protocol violation; behaviour is undefined.

Test Plan:
- Single requester: req[1]=1, addr=0x1000; gnt held high; valid 2 cycles later with rdata=0xCAFE0001. Required: gnt_o[1] in the grant cycle; valid_o[1] with rdata 0xCAFE0001; outstanding_o 0→1→0.
- Round-robin: req=4'b1111 held, gnt always 1, NUM_REQ=4. Required: grant order 0,1,2,3,0.
- Grant stall with lock: req[2] raised at addr 0x2000, gnt=0 for 3 cycles, then req[0] also raised. Required: addr stays 0x2000 and gnt_o[2] is issued before any grant to 0.
- Full FIFO: 4 grants with no valid. Required: outstanding_o=4 and mem_req=0. Then one valid: head requester receives valid_o; next cycle mem_req=1 again.
- Interleaved routing: grants to requesters 3,1,3. Responses rdata 0xA,0xB,0xC are routed to requesters 3,1,3 respectively, including a cycle with simultaneous grant and valid.
- Spurious valid: valid with empty FIFO. Required: error_o=1 and stays 1; no valid_o asserted. Async reset mid-stream with 2 outstanding: outstanding_o=0 and error_o=0 immediately.
